register_file_sb: RTL

Parametrised successor register file with a busy-bit scoreboard for the CPU core datapath. It holds 2**ADDR_W registers of DATA_W bits, with one write port and two registered read ports (rs, rt) that operate in the same cycle. Each register carries a busy bit: the issue stage reserves the bit for an in-flight destination, and writeback clears it. The read ports return data together with that register's busy status so the core can stall on hazards.

---
 rtl/register_file_sb_if.sv | 30 +++
 rtl/register_file_sb.sv | 103 ++++++++++
 2 files changed

// File: rtl/register_file_sb_if.sv
// Bus interface for register_file_sb: write port, alloc request and the two read ports.
interface register_file_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              write;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] data;
    logic              alloc;
    logic [ADDR_W-1:0] alloc_addr;
    logic              alloc_ok;
    logic              read_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output write, rd_addr, data, alloc, alloc_addr, read_en, rs_addr, rt_addr,
        input  alloc_ok, rs_data, rt_data, rs_busy, rt_busy, busy_count
    );

    modport slave (
        input  write, rd_addr, data, alloc, alloc_addr, read_en, rs_addr, rt_addr,
        output alloc_ok, rs_data, rt_data, rs_busy, rt_busy, busy_count
    );
endinterface

// File: rtl/register_file_sb.sv
// Register file with per-register busy scoreboard, one write port and two registered read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy into the read ports.
module register_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input logic               clock,
    input logic               reset_n,
    register_file_sb_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [Depth];
    logic [DATA_W-1:0] regs_d [Depth];
    logic [Depth-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
    logic              rs_busy_q, rs_busy_d, rt_busy_q, rt_busy_d;
    logic              wr_en, alloc_ok, alloc_set;

    always_comb begin
        wr_en     = bus.write && !((ZERO_REG != 0) && (bus.rd_addr == '0));
        alloc_ok  = bus.alloc && (!busy_q[bus.alloc_addr] ||
                                  (bus.write && (bus.rd_addr == bus.alloc_addr)));
        // Register 0 under ZERO_REG accepts the alloc but never becomes busy.
        alloc_set = alloc_ok && !((ZERO_REG != 0) && (bus.alloc_addr == '0));
    end

    assign bus.alloc_ok = alloc_ok;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[bus.rd_addr] = bus.data;
            busy_d[bus.rd_addr] = 1'b0;
        end
        // Applied after the write so a new producer wins over a retiring one.
        if (alloc_set) begin
            busy_d[bus.alloc_addr] = 1'b1;
        end
        busy_count_d = '0;
        for (int i = 0; i < Depth; i++) begin
            busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_comb begin
        rs_data_d = rs_data_q;
        rs_busy_d = rs_busy_q;
        rt_data_d = rt_data_q;
        rt_busy_d = rt_busy_q;
        if (bus.read_en) begin
            rs_data_d = regs_q[bus.rs_addr];
            rs_busy_d = busy_q[bus.rs_addr];
            rt_data_d = regs_q[bus.rt_addr];
            rt_busy_d = busy_q[bus.rt_addr];
            if (BypassEn && wr_en && (bus.rs_addr == bus.rd_addr)) begin
                rs_data_d = bus.data;
                rs_busy_d = busy_d[bus.rs_addr];
            end
            if (BypassEn && wr_en && (bus.rt_addr == bus.rd_addr)) begin
                rt_data_d = bus.data;
                rt_busy_d = busy_d[bus.rt_addr];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            rs_busy_q    <= 1'b0;
            rt_busy_q    <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            rs_busy_q    <= rs_busy_d;
            rt_busy_q    <= rt_busy_d;
        end
    end

    assign bus.rs_data    = rs_data_q;
    assign bus.rt_data    = rt_data_q;
    assign bus.rs_busy    = rs_busy_q;
    assign bus.rt_busy    = rt_busy_q;
    assign bus.busy_count = busy_count_q;
endmodule
